// File: rtl/lag_sensor_rx_if.sv
// Handshake bundle between the lag-test pattern side and the photodiode receiver.
interface lag_sensor_rx_if #(parameter int CNT_W = 24);
  logic             start;
  logic             sensor_in;
  logic             clear;
  logic             sensor_lvl;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] latency;
  logic [CNT_W-1:0] lat_min;
  logic [CNT_W-1:0] lat_max;
  logic [7:0]       meas_cnt;

  modport master (
    output start, sensor_in, clear,
    input  sensor_lvl, busy, done, status, latency, lat_min, lat_max, meas_cnt
  );

  modport slave (
    input  start, sensor_in, clear,
    output sensor_lvl, busy, done, status, latency, lat_min, lat_max, meas_cnt
  );
endinterface

// File: rtl/lag_sensor_rx.sv
// Photodiode receiver: sync + debounce, then times start -> sensor lit in clk cycles.
// Optional running min/max/count tracking is compiled in with LAG_RX_MINMAX_EN.
module lag_sensor_rx #(
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4000000
) (
  input  logic            clk,
  input  logic            reset,
  lag_sensor_rx_if.slave  bus
);
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_LIT     = 2'd2;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t           state;
  logic             sync1, s, lvl;
  logic [7:0]       run;
  logic [CNT_W-1:0] cnt, edge_cnt, latency;
  logic             busy, done;
  logic [1:0]       status;
  logic             s_rise;

  // sync1 is what s takes on this edge, so this marks the edge where s goes 0->1
  assign s_rise = sync1 & ~s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      lvl   <= 1'b0;
      run   <= '0;
    end else begin
      sync1 <= bus.sensor_in;
      s     <= sync1;
      if (s == lvl)
        run <= '0;
      else if (run == 8'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= s;
        run <= '0;
      end else
        run <= run + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      status   <= ST_OK;
      latency  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt      <= '0;
            edge_cnt <= '0;
            if (lvl) begin
              state   <= DONE;
              done    <= 1'b1;
              status  <= ST_LIT;
              latency <= '1;
            end else begin
              state <= MEASURE;
              busy  <= 1'b1;
            end
          end
        end
        MEASURE: begin
          // restart drops the current run silently; acceptance outranks timeout
          if (bus.start) begin
            cnt      <= '0;
            edge_cnt <= '0;
          end else if (lvl) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            status  <= ST_OK;
            latency <= edge_cnt;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            status  <= ST_TIMEOUT;
            latency <= '1;
          end else begin
            cnt <= cnt + 1'b1;
            if (s_rise) edge_cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sensor_lvl = lvl;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.status     = status;
  assign bus.latency    = latency;

`ifdef LAG_RX_MINMAX_EN
  logic [CNT_W-1:0] lat_min, lat_max;
  logic [7:0]       meas_cnt;

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      lat_min  <= '1;
      lat_max  <= '0;
      meas_cnt <= '0;
    end else if (done && status == ST_OK) begin
      if (latency < lat_min) lat_min <= latency;
      if (latency > lat_max) lat_max <= latency;
      if (meas_cnt != 8'hff) meas_cnt <= meas_cnt + 8'd1;
    end
  end

  assign bus.lat_min  = lat_min;
  assign bus.lat_max  = lat_max;
  assign bus.meas_cnt = meas_cnt;
`else
  assign bus.lat_min  = '0;
  assign bus.lat_max  = '0;
  assign bus.meas_cnt = '0;
`endif

endmodule
